fft_agu_ctrl: RTL and testbench

- Sequencing controller for the radix-2, in-place, ping-pong FFT datapath.
- On start, steps through all N_LOG2 stages and issues one butterfly per cycle to the BFU.
- Drives read addresses A/B, the twiddle ROM index, in_valid and the RAM bank select.
- Inserts a drain gap between stages so every BFU write lands before the next stage reads. Sits between the top-level FFT control and the dual-port RAMs, twiddle ROM and BFU.

---
 rtl/fft_agu_ctrl.sv | 179 +++++++++++++++++
 tb/tb_fft_agu_ctrl.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_agu_ctrl.sv
// Purpose : address-generation / sequencing controller for a radix-2 in-place ping-pong FFT.
// Latency : start sampled at edge 0 -> first butterfly at cycle 1; done at N_LOG2*(N/2+DRAIN_CYC)+1.
// Backpressure: none by default; with FFT_AGU_STALL_EN a stall input freezes issue in RUN/DRAIN.
//
// Optional feature macro: FFT_AGU_STALL_EN (adds the 'stall' input).
//
// Ports:
//   clk, rst           clock (rising edge), synchronous active-high reset
//   stall              (FFT_AGU_STALL_EN only) freeze issue/drain while high
//   start              begin an FFT, sampled only in IDLE
//   busy, done         busy in RUN/DRAIN; done is a one-cycle completion pulse
//   stage              current stage index
//   rd_addrA/rd_addrB  butterfly read addresses
//   twiddle_idx        twiddle ROM index
//   in_valid           addresses/twiddle valid this cycle
//   bank_sel           0: read RAM A / write RAM B, 1: read RAM B / write RAM A
module fft_agu_ctrl #(
    parameter int N_LOG2     = 10,
    parameter int BFU_LAT    = 3,
    parameter int RAM_RD_LAT = 1,
    parameter int DRAIN_CYC  = BFU_LAT + RAM_RD_LAT
) (
    input  logic              clk,
    input  logic              rst,
`ifdef FFT_AGU_STALL_EN
    input  logic              stall,
`endif
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [N_LOG2-1:0] stage,
    output logic [N_LOG2-1:0] rd_addrA,
    output logic [N_LOG2-1:0] rd_addrB,
    output logic [N_LOG2-2:0] twiddle_idx,
    output logic              in_valid,
    output logic              bank_sel
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam int DCW     = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC + 1) : 1;
    localparam int ONE_INT = 1;
    localparam int LS_INT  = N_LOG2 - 1;
    localparam int DL_INT  = DRAIN_CYC - 1;

    localparam logic [N_LOG2-1:0] ONE        = ONE_INT[N_LOG2-1:0];
    localparam logic [N_LOG2-1:0] LAST_STAGE = LS_INT[N_LOG2-1:0];
    localparam logic [N_LOG2-1:0] HALF       = {1'b1, {(N_LOG2-1){1'b0}}};
    localparam logic [N_LOG2-2:0] ALL1_LO    = {(N_LOG2-1){1'b1}};
    localparam logic [DCW-1:0]    DCNT_ONE   = ONE_INT[DCW-1:0];
    localparam logic [DCW-1:0]    DRAIN_LAST = DL_INT[DCW-1:0];

    logic [1:0]        state;
    // k is the index of the next butterfly to issue; it reaches N/2 once the
    // stage's last butterfly has gone out, hence the extra bit.
    logic [N_LOG2-1:0] k;
    logic [DCW-1:0]    dcnt;
    logic              hold;

`ifdef FFT_AGU_STALL_EN
    assign hold = stall;
`else
    assign hold = 1'b0;
`endif

    // Address of the butterfly that would be issued at the coming edge.
    // From IDLE that is stage 0/k 0, from DRAIN it is the next stage's k 0.
    logic [N_LOG2-1:0] iss_stage;
    logic [N_LOG2-1:0] iss_k;
    logic [N_LOG2-2:0] mask_lo;
    logic [N_LOG2-1:0] nxt_a;
    logic [N_LOG2-1:0] nxt_b;
    logic [N_LOG2-2:0] nxt_tw;

    always_comb begin
        iss_stage = stage;
        iss_k     = k;
        if (state == S_DRAIN) begin
            iss_stage = stage + ONE;
            iss_k     = '0;
        end else if (state != S_RUN) begin
            iss_stage = '0;
            iss_k     = '0;
        end
        // mask_lo = span-1; span never exceeds N/2 so it fits in N_LOG2-1 bits.
        mask_lo = ~(ALL1_LO << iss_stage);
        // Insert a zero at bit position 'stage' of k to get address A; B sets that bit.
        nxt_a   = ((iss_k >> iss_stage) << (iss_stage + ONE))
                | {1'b0, iss_k[N_LOG2-2:0] & mask_lo};
        nxt_b   = nxt_a | (ONE << iss_stage);
        nxt_tw  = (iss_k[N_LOG2-2:0] & mask_lo) << (LAST_STAGE - iss_stage);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            k           <= '0;
            dcnt        <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            in_valid    <= 1'b0;
            stage       <= '0;
            bank_sel    <= 1'b0;
            rd_addrA    <= '0;
            rd_addrB    <= '0;
            twiddle_idx <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    // stage/bank_sel hold so the finished result bank stays addressable
                    if (start) begin
                        state       <= S_RUN;
                        stage       <= '0;
                        bank_sel    <= 1'b0;
                        busy        <= 1'b1;
                        in_valid    <= 1'b1;
                        rd_addrA    <= nxt_a;
                        rd_addrB    <= nxt_b;
                        twiddle_idx <= nxt_tw;
                        k           <= ONE;
                    end
                end
                S_RUN: begin
                    if (hold) begin
                        // addresses keep their last value; only the valid drops
                        in_valid <= 1'b0;
                    end else if (k == HALF) begin
                        state       <= S_DRAIN;
                        in_valid    <= 1'b0;
                        rd_addrA    <= '0;
                        rd_addrB    <= '0;
                        twiddle_idx <= '0;
                        dcnt        <= '0;
                    end else begin
                        in_valid    <= 1'b1;
                        rd_addrA    <= nxt_a;
                        rd_addrB    <= nxt_b;
                        twiddle_idx <= nxt_tw;
                        k           <= k + ONE;
                    end
                end
                S_DRAIN: begin
                    if (!hold) begin
                        if (dcnt == DRAIN_LAST) begin
                            if (stage == LAST_STAGE) begin
                                state <= S_DONE;
                                busy  <= 1'b0;
                                done  <= 1'b1;
                            end else begin
                                // next stage's first butterfly goes out on this edge
                                state       <= S_RUN;
                                stage       <= stage + ONE;
                                bank_sel    <= ~bank_sel;
                                in_valid    <= 1'b1;
                                rd_addrA    <= nxt_a;
                                rd_addrB    <= nxt_b;
                                twiddle_idx <= nxt_tw;
                                k           <= ONE;
                            end
                        end else begin
                            dcnt <= dcnt + DCNT_ONE;
                        end
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fft_agu_ctrl.sv
// Purpose : directed self-checking bench for fft_agu_ctrl (N_LOG2=3 instance plus default instance).
// Latency : outputs sampled 1 ns after each rising edge; cycle c is the interval after edge c.
// Backpressure: stall scenario only exercised when FFT_AGU_STALL_EN is defined.
module tb_fft_agu_ctrl;

    logic clk = 1'b0;
    logic rst;
    logic start_s, start_d;
`ifdef FFT_AGU_STALL_EN
    logic stall_s, stall_d;
`endif

    logic       s_busy, s_done, s_in_valid, s_bank_sel;
    logic [2:0] s_stage, s_a, s_b;
    logic [1:0] s_tw;

    logic       d_busy, d_done, d_in_valid, d_bank_sel;
    logic [9:0] d_stage, d_a, d_b;
    logic [8:0] d_tw;

    int tests = 0;
    int fails = 0;

    // Stage 0, 1, 2 butterflies for N = 8, hand-computed.
    logic [2:0] exp_a  [12] = '{0, 2, 4, 6, 0, 1, 4, 5, 0, 1, 2, 3};
    logic [2:0] exp_b  [12] = '{1, 3, 5, 7, 2, 3, 6, 7, 4, 5, 6, 7};
    logic [1:0] exp_tw [12] = '{0, 0, 0, 0, 0, 2, 0, 2, 0, 1, 2, 3};

    always #5 clk = ~clk;

    fft_agu_ctrl #(.N_LOG2(3)) dut_s (
        .clk         (clk),
        .rst         (rst),
`ifdef FFT_AGU_STALL_EN
        .stall       (stall_s),
`endif
        .start       (start_s),
        .busy        (s_busy),
        .done        (s_done),
        .stage       (s_stage),
        .rd_addrA    (s_a),
        .rd_addrB    (s_b),
        .twiddle_idx (s_tw),
        .in_valid    (s_in_valid),
        .bank_sel    (s_bank_sel)
    );

    fft_agu_ctrl dut_d (
        .clk         (clk),
        .rst         (rst),
`ifdef FFT_AGU_STALL_EN
        .stall       (stall_d),
`endif
        .start       (start_d),
        .busy        (d_busy),
        .done        (d_done),
        .stage       (d_stage),
        .rd_addrA    (d_a),
        .rd_addrB    (d_b),
        .twiddle_idx (d_tw),
        .in_valid    (d_in_valid),
        .bank_sel    (d_bank_sel)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start_s = 1'b0;
        start_d = 1'b0;
`ifdef FFT_AGU_STALL_EN
        stall_s = 1'b0;
        stall_d = 1'b0;
`endif
        tick();
        tick();
        rst = 1'b0;
        tests++;
        if ({s_busy, s_done, s_in_valid, s_bank_sel, s_stage, s_a, s_b, s_tw} !== 15'd0) begin
            fails++;
            $display("FAIL reset_small: got %h expected 0",
                     {s_busy, s_done, s_in_valid, s_bank_sel, s_stage, s_a, s_b, s_tw});
        end
        tests++;
        if ({d_busy, d_done, d_in_valid, d_bank_sel, d_stage, d_a, d_b, d_tw} !== 43'd0) begin
            fails++;
            $display("FAIL reset_default: got %h expected 0",
                     {d_busy, d_done, d_in_valid, d_bank_sel, d_stage, d_a, d_b, d_tw});
        end
    endtask

    task automatic test_pattern();
        int idx = 0;
        int gap = 0;
        int ndone = 0;
        int done_cyc = -1;
        logic exp_busy;
        pulse_reset();
        start_s = 1'b1;
        tick();
        start_s = 1'b0;
        for (int c = 1; c <= 32; c++) begin
            if (s_in_valid) begin
                if (idx < 12) begin
                    tests++;
                    if ({s_a, s_b, s_tw} !== {exp_a[idx], exp_b[idx], exp_tw[idx]}) begin
                        fails++;
                        $display("FAIL issue%0d_addr: got A=%0d B=%0d tw=%0d expected A=%0d B=%0d tw=%0d",
                                 idx, s_a, s_b, s_tw, exp_a[idx], exp_b[idx], exp_tw[idx]);
                    end
                    tests++;
                    if (s_stage !== 3'(idx / 4) || s_bank_sel !== 1'((idx / 4) % 2)) begin
                        fails++;
                        $display("FAIL issue%0d_stage_bank: got stage=%0d bank=%0d expected stage=%0d bank=%0d",
                                 idx, s_stage, s_bank_sel, idx / 4, (idx / 4) % 2);
                    end
                    tests++;
                    if (gap != ((idx > 0 && idx % 4 == 0) ? 4 : 0)) begin
                        fails++;
                        $display("FAIL issue%0d_gap: got %0d idle cycles expected %0d",
                                 idx, gap, (idx > 0 && idx % 4 == 0) ? 4 : 0);
                    end
                end
                gap = 0;
                idx++;
            end else if (idx > 0) begin
                gap++;
            end
            exp_busy = (c <= 24);
            tests++;
            if (s_busy !== exp_busy) begin
                fails++;
                $display("FAIL busy_c%0d: got %0b expected %0b", c, s_busy, exp_busy);
            end
            if (s_done) begin
                ndone++;
                done_cyc = c;
            end
            tick();
        end
        tests++;
        if (idx != 12) begin
            fails++;
            $display("FAIL issue_count: got %0d expected 12", idx);
        end
        tests++;
        if (ndone != 1 || done_cyc != 25) begin
            fails++;
            $display("FAIL done_timing: got %0d pulses last at cycle %0d expected 1 at cycle 25", ndone, done_cyc);
        end
        tests++;
        if ({s_stage, s_bank_sel, s_busy} !== {3'd2, 1'b0, 1'b0}) begin
            fails++;
            $display("FAIL final_state: got stage=%0d bank=%0d busy=%0b expected stage=2 bank=0 busy=0",
                     s_stage, s_bank_sel, s_busy);
        end
    endtask

    task automatic test_start_held();
        int early_done = 0;
        pulse_reset();
        start_s = 1'b1;
        tick();
        for (int c = 1; c <= 27; c++) begin
            if (c < 25 && s_done) early_done++;
            if (c == 25) begin
                tests++;
                if ({s_done, s_busy} !== 2'b10) begin
                    fails++;
                    $display("FAIL held_done: got done=%0b busy=%0b expected done=1 busy=0", s_done, s_busy);
                end
            end
            if (c == 26) begin
                tests++;
                if ({s_done, s_busy, s_in_valid} !== 3'b000) begin
                    fails++;
                    $display("FAIL held_idle: got done=%0b busy=%0b vld=%0b expected 0 0 0",
                             s_done, s_busy, s_in_valid);
                end
            end
            if (c == 27) begin
                tests++;
                if ({s_busy, s_in_valid, s_stage, s_a, s_b} !== {1'b1, 1'b1, 3'd0, 3'd0, 3'd1}) begin
                    fails++;
                    $display("FAIL held_restart: got busy=%0b vld=%0b stage=%0d A=%0d B=%0d expected 1 1 0 0 1",
                             s_busy, s_in_valid, s_stage, s_a, s_b);
                end
            end
            tick();
        end
        start_s = 1'b0;
        tests++;
        if (early_done != 0) begin
            fails++;
            $display("FAIL held_early_done: got %0d expected 0", early_done);
        end
    endtask

    task automatic test_reset_midrun();
        int ndone = 0;
        int nbusy = 0;
        pulse_reset();
        start_s = 1'b1;
        tick();
        start_s = 1'b0;
        for (int c = 1; c < 10; c++) tick();
        tests++;
        if ({s_in_valid, s_stage, s_bank_sel} !== {1'b1, 3'd1, 1'b1}) begin
            fails++;
            $display("FAIL midrun_pre: got vld=%0b stage=%0d bank=%0b expected 1 1 1",
                     s_in_valid, s_stage, s_bank_sel);
        end
        rst = 1'b1;
        tick();
        tests++;
        if ({s_busy, s_done, s_in_valid, s_bank_sel, s_stage, s_a, s_b, s_tw} !== 15'd0) begin
            fails++;
            $display("FAIL midrun_reset1: got %h expected 0",
                     {s_busy, s_done, s_in_valid, s_bank_sel, s_stage, s_a, s_b, s_tw});
        end
        tick();
        rst = 1'b0;
        tests++;
        if ({s_busy, s_done, s_in_valid, s_bank_sel, s_stage, s_a, s_b, s_tw} !== 15'd0) begin
            fails++;
            $display("FAIL midrun_reset2: got %h expected 0",
                     {s_busy, s_done, s_in_valid, s_bank_sel, s_stage, s_a, s_b, s_tw});
        end
        for (int c = 0; c < 30; c++) begin
            if (s_done) ndone++;
            if (s_busy) nbusy++;
            tick();
        end
        tests++;
        if (ndone != 0 || nbusy != 0) begin
            fails++;
            $display("FAIL midrun_aborted: got done=%0d busy=%0d cycles expected 0 0", ndone, nbusy);
        end
    endtask

    task automatic test_defaults();
        int nvld = 0;
        int done_cyc = -1;
        start_d = 1'b1;
        tick();
        start_d = 1'b0;
        for (int c = 1; c <= 6000 && done_cyc < 0; c++) begin
            if (d_in_valid) nvld++;
            if (d_done) done_cyc = c;
            else tick();
        end
        tests++;
        if (done_cyc != 5161) begin
            fails++;
            $display("FAIL default_done_cycle: got %0d expected 5161 (-1 means timeout)", done_cyc);
        end
        tests++;
        if (nvld != 5120) begin
            fails++;
            $display("FAIL default_valid_count: got %0d expected 5120", nvld);
        end
        tests++;
        if ({d_bank_sel, d_stage, d_busy} !== {1'b1, 10'd9, 1'b0}) begin
            fails++;
            $display("FAIL default_final: got bank=%0b stage=%0d busy=%0b expected 1 9 0",
                     d_bank_sel, d_stage, d_busy);
        end
        tick();
    endtask

`ifdef FFT_AGU_STALL_EN
    task automatic test_stall();
        int nvld = 0;
        int done_cyc = -1;
        pulse_reset();
        start_s = 1'b1;
        tick();
        start_s = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            if (c == 10) stall_s = 1'b1;
            if (c == 13) stall_s = 1'b0;
            if (s_in_valid) nvld++;
            if (s_done && done_cyc < 0) done_cyc = c;
            if (c == 11) begin
                tests++;
                if ({s_in_valid, s_a, s_b, s_busy} !== {1'b0, 3'd1, 3'd3, 1'b1}) begin
                    fails++;
                    $display("FAIL stall_hold: got vld=%0b A=%0d B=%0d busy=%0b expected 0 1 3 1",
                             s_in_valid, s_a, s_b, s_busy);
                end
            end
            if (c == 14) begin
                tests++;
                if ({s_in_valid, s_stage, s_a, s_b, s_tw} !== {1'b1, 3'd1, 3'd4, 3'd6, 2'd0}) begin
                    fails++;
                    $display("FAIL stall_resume: got vld=%0b stage=%0d A=%0d B=%0d tw=%0d expected 1 1 4 6 0",
                             s_in_valid, s_stage, s_a, s_b, s_tw);
                end
            end
            tick();
        end
        tests++;
        if (done_cyc != 28) begin
            fails++;
            $display("FAIL stall_done_cycle: got %0d expected 28", done_cyc);
        end
        tests++;
        if (nvld != 12) begin
            fails++;
            $display("FAIL stall_valid_count: got %0d expected 12", nvld);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_pattern();
        test_start_held();
        test_reset_midrun();
        test_defaults();
`ifdef FFT_AGU_STALL_EN
        test_stall();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
